// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and full-flag generator for an asynchronous FIFO.
// Keeps the binary and Gray write pointers and brings the read Gray pointer
// into clk_w through two flops. From these it produces the registered full
// flag, the write-side fill level and a sticky overflow flag. A write is never
// accepted while full is set.
//
// Optional feature: define FIFO_WPTR_AFULL_EN to build a registered
// almost-full flag (afull = level >= afull_thr). Without the macro, afull is
// tied to 0.
module fifo_wptr_full #(
  parameter int unsigned ptrsize   = 10,
  parameter int unsigned depth     = 1024,
  parameter int unsigned afull_thr = depth - 4
) (
  input  logic               clk_w,
  input  logic               rst_w,
  input  logic               wen,
  input  logic [ptrsize:0]   rptr_gray,
  output logic               wr_accept,
  output logic [ptrsize-1:0] wptr,
  output logic [ptrsize:0]   wptr_gray,
  output logic               full,
  output logic [ptrsize:0]   wlevel,
  output logic               overflow,
  output logic               afull
);

  // The full compare splits the top two pointer bits from the rest.
  if (ptrsize < 2) begin : g_bad_ptrsize
    $fatal(1, "fifo_wptr_full: ptrsize must be at least 2");
  end
  if (depth != 2 ** ptrsize) begin : g_bad_depth
    $fatal(1, "fifo_wptr_full: depth must equal 2**ptrsize");
  end

  localparam logic [ptrsize:0] PtrOne = (ptrsize + 1)'(1);

  // Binary write pointer, one bit wider than the address so that the top bit
  // records the wrap.
  logic [ptrsize:0] wbin;
  logic [ptrsize:0] wbin_next;
  logic [ptrsize:0] wgray_next;

  // Two-flop synchroniser for the read Gray pointer. Only rq2 is used.
  logic [ptrsize:0] rq1;
  logic [ptrsize:0] rq2;

  // Read pointer in binary, decoded from rq2.
  logic [ptrsize:0] rbin_s;

  logic [ptrsize:0] wlevel_next;
  logic             full_next;

  // Writes are gated by the registered full flag only.
  assign wr_accept = wen & ~full;

  // Bring the read Gray pointer into clk_w.
  always_ff @(posedge clk_w) begin
    if (rst_w) begin
      rq1 <= '0;
      rq2 <= '0;
    end else begin
      rq1 <= rptr_gray;
      rq2 <= rq1;
    end
  end

  // Gray-to-binary: each binary bit is the XOR of that Gray bit and every
  // Gray bit above it.
  always_comb begin
    rbin_s = '0;
    for (int i = 0; i <= int'(ptrsize); i++) begin
      rbin_s[i] = ^(rq2 >> i);
    end
  end

  // Next pointer, its Gray code, and the level and full flag that follow from
  // it.
  always_comb begin
    wbin_next   = wr_accept ? (wbin + PtrOne) : wbin;
    wgray_next  = wbin_next ^ (wbin_next >> 1);
    // Modulo 2**(ptrsize+1) subtraction is unaffected by the wrap.
    wlevel_next = wbin_next - rbin_s;
    // Full when the Gray pointers differ only in their top two bits.
    full_next   = (wgray_next == {~rq2[ptrsize:ptrsize-1], rq2[ptrsize-2:0]});
  end

  // Write pointer registers. Reset takes priority over a pending write.
  always_ff @(posedge clk_w) begin
    if (rst_w) begin
      wbin      <= '0;
      wptr      <= '0;
      wptr_gray <= '0;
    end else begin
      wbin      <= wbin_next;
      wptr      <= wbin_next[ptrsize-1:0];
      wptr_gray <= wgray_next;
    end
  end

  // Status flags. These are pessimistic because rq2 lags the real read
  // pointer.
  always_ff @(posedge clk_w) begin
    if (rst_w) begin
      full   <= 1'b0;
      wlevel <= '0;
    end else begin
      full   <= full_next;
      wlevel <= wlevel_next;
    end
  end

  // Sticky overflow: set when a write is attempted against a full FIFO.
  always_ff @(posedge clk_w) begin
    if (rst_w) begin
      overflow <= 1'b0;
    end else if (wen && full) begin
      overflow <= 1'b1;
    end
  end

`ifdef FIFO_WPTR_AFULL_EN
  localparam logic [ptrsize:0] AfullThr = (ptrsize + 1)'(afull_thr);

  // Almost-full flag, registered together with the level it is derived from.
  always_ff @(posedge clk_w) begin
    if (rst_w) begin
      afull <= 1'b0;
    end else begin
      afull <= (wlevel_next >= AfullThr);
    end
  end
`else
  assign afull = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Scoreboard bench for fifo_wptr_full (ptrsize=4, depth=16, afull_thr=12).
// The reference model counts writes and reads as plain integers. The read
// count that the write side sees lags the real one by two edges.
module tb_fifo_wptr_full;

  localparam int unsigned PtrSize = 4;
  localparam int unsigned Depth   = 16;
  localparam int unsigned Thr     = 12;

  logic               clk_w = 1'b0;
  logic               rst_w;
  logic               wen;
  logic [PtrSize:0]   rptr_gray;
  logic               wr_accept;
  logic [PtrSize-1:0] wptr;
  logic [PtrSize:0]   wptr_gray;
  logic               full;
  logic [PtrSize:0]   wlevel;
  logic               overflow;
  logic               afull;

  fifo_wptr_full #(
    .ptrsize  (PtrSize),
    .depth    (Depth),
    .afull_thr(Thr)
  ) dut (
    .clk_w    (clk_w),
    .rst_w    (rst_w),
    .wen      (wen),
    .rptr_gray(rptr_gray),
    .wr_accept(wr_accept),
    .wptr     (wptr),
    .wptr_gray(wptr_gray),
    .full     (full),
    .wlevel   (wlevel),
    .overflow (overflow),
    .afull    (afull)
  );

  always #5 clk_w = ~clk_w;

  typedef struct {
    logic       acc;
    logic [3:0] wptr;
    logic [4:0] wgray;
    logic       full;
    logic [4:0] level;
    logic       ovf;
    logic       afull;
  } item_t;

  item_t q[$];

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: total writes, total reads, and the read counts
  // that are one and two edges old in the write domain.
  int wcount  = 0;
  int rcount  = 0;
  int rseen1  = 0;
  int rseen2  = 0;
  int lvl_m   = 0;
  bit full_m  = 1'b0;
  bit ovf_m   = 1'b0;
  bit afull_m = 1'b0;

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and queue the response the model predicts.
  task automatic step(input bit r, input bit w, input bit rd);
    item_t it;
    @(negedge clk_w);
    it.acc = w && !full_m;
    if (r) begin
      wcount = 0; rcount = 0; rseen1 = 0; rseen2 = 0;
      lvl_m = 0; full_m = 0; ovf_m = 0; afull_m = 0;
    end else begin
      if (rd && rcount < wcount) rcount++;
      if (w && full_m) ovf_m = 1'b1;
      if (it.acc) wcount++;
      lvl_m  = wcount - rseen2;
      full_m = (lvl_m == int'(Depth));
`ifdef FIFO_WPTR_AFULL_EN
      afull_m = (lvl_m >= int'(Thr));
`else
      afull_m = 1'b0;
`endif
      rseen2 = rseen1;
      rseen1 = rcount;
    end
    rst_w     = r;
    wen       = w;
    rptr_gray = to_gray(rcount % 32);
    it.wptr   = 4'(wcount % 16);
    it.wgray  = to_gray(wcount % 32);
    it.full   = full_m;
    it.level  = 5'(lvl_m);
    it.ovf    = ovf_m;
    it.afull  = afull_m;
    #1 q.push_back(it);
  endtask

  // Monitor: check wr_accept while the inputs are stable, then the registered
  // outputs just after the edge.
  initial begin
    item_t it;
    forever begin
      @(negedge clk_w);
      #2;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("wr_accept", 32'(wr_accept), 32'(it.acc));
        @(posedge clk_w);
        #1;
        chk("wptr", 32'(wptr), 32'(it.wptr));
        chk("wptr_gray", 32'(wptr_gray), 32'(it.wgray));
        chk("full", 32'(full), 32'(it.full));
        chk("wlevel", 32'(wlevel), 32'(it.level));
        chk("overflow", 32'(overflow), 32'(it.ovf));
        chk("afull", 32'(afull), 32'(it.afull));
      end
    end
  end

  // A single Gray bit must change on every accepted write.
  logic [4:0] prev_gray;
  always @(posedge clk_w) begin
    prev_gray <= wptr_gray;
    #1;
    if (!rst_w && wptr_gray !== prev_gray) begin
      chk("gray_one_bit", 32'($countones(wptr_gray ^ prev_gray)), 32'd1);
    end
  end

  initial begin
    int guard;
    rst_w = 1'b1; wen = 1'b0; rptr_gray = '0;

    step(1, 0, 0);
    step(1, 0, 0);

    // 16 writes fill the FIFO, the 17th is refused and sets overflow.
    for (int i = 0; i < 17; i++) step(0, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0);

    // One read releases full three edges later.
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);

    // Drain to a modest level.
    for (int i = 0; i < 8; i++) step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // Random fill/drain holding the level at or below 10, crossing the wrap.
    for (int i = 0; i < 300; i++) begin
      step(0, ($urandom_range(0, 1) == 1) && (wcount - rseen2 < 10),
           $urandom_range(0, 1) == 1);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0);

    // Bring the level to exactly 9, then reset while a write is requested.
    guard = 0;
    while (lvl_m != 9 && guard < 200) begin
      guard++;
      if (lvl_m < 9) step(0, 1, 0);
      else begin
        step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
      end
    end
    chk("level_reached_9", 32'(lvl_m), 32'd9);
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 0, 0);

    // Almost-full ramp: rise at 12, fall at 11.
    for (int i = 0; i < 12; i++) step(0, 1, 0);
    step(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1); step(0, 0, 0); step(0, 0, 0);
    end
    step(0, 0, 0);

    // Wait for the monitor to empty the queue.
    guard = 0;
    while (q.size() > 0 && guard < 10) begin
      @(posedge clk_w);
      guard++;
    end
    repeat (2) @(posedge clk_w);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
